cfg_stream_loader: RTL and testbench

CFG_STREAM_LOADER -- requirements
Module: cfg_stream_loader

---
 rtl/cfg_stream_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_cfg_stream_loader.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_stream_loader.sv
// Configuration stream loader: writes NUM_FRAMES words into fabric frames, then settles and arms the fabric.
// Optional trailing XOR checksum frame is enabled by defining CFG_CHECKSUM_EN.
module cfg_stream_loader #(
    parameter int CFG_WIDTH     = 224,
    parameter int NUM_FRAMES    = 245,
    parameter int SETTLE_CYCLES = 10,
    parameter int ARM_CYCLES    = 10
) (
    input  logic                            clock,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            cfg_valid,
    input  logic [CFG_WIDTH-1:0]            cfg_data,
    output logic                            cfg_ready,
    output logic [CFG_WIDTH-1:0]            configs_in,
    output logic [NUM_FRAMES-1:0]           configs_en,
    output logic                            ff_en,
    output logic                            rdy,
    output logic                            busy,
    output logic                            error,
    output logic [$clog2(NUM_FRAMES+1)-1:0] frame_count
);
    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | cfg_ready high, waiting for the next frame word
    // WRITE  | one-cycle one-hot configs_en pulse for the accepted frame
    // CHECK  | waiting for the checksum word (CFG_CHECKSUM_EN only)
    // SETTLE | idle gap before enabling fabric flip-flops
    // ARM    | ff_en high, waiting before rdy
    // DONE   | configured; ff_en and rdy held
    // ERROR  | checksum mismatch; error held (CFG_CHECKSUM_EN only)

    localparam int FCW   = $clog2(NUM_FRAMES + 1);
    localparam int S_EFF = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES : 1;
    localparam int A_EFF = (ARM_CYCLES > 0) ? ARM_CYCLES : 1;
    localparam int T_MAX = (S_EFF > A_EFF) ? S_EFF : A_EFF;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [FCW-1:0]        LAST_FRAME = FCW'(NUM_FRAMES - 1);
    localparam logic [TW-1:0]         S_LOAD     = TW'(S_EFF - 1);
    localparam logic [TW-1:0]         A_LOAD     = TW'(A_EFF - 1);
    localparam logic [NUM_FRAMES-1:0] EN_ONE     = NUM_FRAMES'(1);

`ifdef CFG_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, SETTLE, ARM, DONE, CHECK, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, SETTLE, ARM, DONE} state_t;
`endif

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          restart;
    logic          accept_frame;
    logic          write_end;
    logic          load_settle;
    logic          load_arm;
    logic          timer_dec;
    logic          enter_done;
`ifdef CFG_CHECKSUM_EN
    logic [CFG_WIDTH-1:0] csum;
    logic                 check_fail;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        cfg_ready    = 1'b0;
        busy         = 1'b0;
        restart      = 1'b0;
        accept_frame = 1'b0;
        write_end    = 1'b0;
        load_settle  = 1'b0;
        load_arm     = 1'b0;
        timer_dec    = 1'b0;
        enter_done   = 1'b0;
`ifdef CFG_CHECKSUM_EN
        check_fail   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_valid) begin
                    accept_frame = 1'b1;
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                write_end = 1'b1;
                if (frame_count != LAST_FRAME) begin
                    state_next = LOAD;
                end else begin
`ifdef CFG_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next  = SETTLE;
                    load_settle = 1'b1;
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            CHECK: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_valid) begin
                    if (cfg_data == csum) begin
                        state_next  = SETTLE;
                        load_settle = 1'b1;
                    end else begin
                        state_next = ERROR;
                        check_fail = 1'b1;
                    end
                end
            end
            ERROR: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
`endif
            SETTLE: begin
                busy = 1'b1;
                if (timer == '0) begin
                    state_next = ARM;
                    load_arm   = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ARM: begin
                busy = 1'b1;
                if (timer == '0) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame datapath and settle/arm down-counter; configs_in only changes on an accepted frame.
    always_ff @(posedge clock) begin
        if (rst) begin
            configs_in  <= '0;
            configs_en  <= '0;
            ff_en       <= 1'b0;
            rdy         <= 1'b0;
            frame_count <= '0;
            timer       <= '0;
        end else begin
            if (restart) begin
                frame_count <= '0;
                timer       <= '0;
                ff_en       <= 1'b0;
                rdy         <= 1'b0;
            end
            if (accept_frame) begin
                configs_in <= cfg_data;
                configs_en <= EN_ONE << frame_count;
            end
            if (write_end) begin
                configs_en  <= '0;
                frame_count <= frame_count + FCW'(1);
            end
            if (load_settle) begin
                timer <= S_LOAD;
            end
            if (load_arm) begin
                timer <= A_LOAD;
                ff_en <= 1'b1;
            end
            if (timer_dec) begin
                timer <= timer - TW'(1);
            end
            if (enter_done) begin
                rdy <= 1'b1;
            end
        end
    end

`ifdef CFG_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            csum  <= '0;
            error <= 1'b0;
        end else begin
            if (restart) begin
                csum  <= '0;
                error <= 1'b0;
            end
            if (accept_frame) begin
                csum <= csum ^ cfg_data;
            end
            if (check_fail) begin
                error <= 1'b1;
            end
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Self-checking bench for cfg_stream_loader: randomized frame streams against a cycle-count model
// derived from the load/settle/arm rules; a second instance covers zero settle/arm delays.
module tb_cfg_stream_loader;
    localparam int CW     = 8;
    localparam int NF     = 4;
    localparam int SC     = 3;
    localparam int AC     = 2;
    localparam int FCW    = $clog2(NF + 1);
    localparam int BUDGET = 200;
`ifdef CFG_CHECKSUM_EN
    localparam int NW = NF + 1;
`else
    localparam int NW = NF;
`endif

    logic           clock     = 1'b0;
    logic           rst       = 1'b1;
    logic           start     = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [CW-1:0]  cfg_data  = '0;

    logic           cfg_ready, ff_en, rdy, busy, error;
    logic [CW-1:0]  configs_in;
    logic [NF-1:0]  configs_en;
    logic [FCW-1:0] frame_count;

    logic           b_cfg_ready, b_ff_en, b_rdy, b_busy, b_error;
    logic [CW-1:0]  b_configs_in;
    logic [NF-1:0]  b_configs_en;
    logic [FCW-1:0] b_frame_count;

    always #5 clock = ~clock;

    cfg_stream_loader #(.CFG_WIDTH(CW), .NUM_FRAMES(NF), .SETTLE_CYCLES(SC), .ARM_CYCLES(AC)) dut (
        .clock(clock), .rst(rst), .start(start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .configs_in(configs_in), .configs_en(configs_en), .ff_en(ff_en),
        .rdy(rdy), .busy(busy), .error(error), .frame_count(frame_count)
    );

    cfg_stream_loader #(.CFG_WIDTH(CW), .NUM_FRAMES(NF), .SETTLE_CYCLES(0), .ARM_CYCLES(0)) dut_fast (
        .clock(clock), .rst(rst), .start(start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(b_cfg_ready), .configs_in(b_configs_in), .configs_en(b_configs_en), .ff_en(b_ff_en),
        .rdy(b_rdy), .busy(b_busy), .error(b_error), .frame_count(b_frame_count)
    );

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] word_tbl [NW];
    logic [NF-1:0] obs_en [8];
    logic [CW-1:0] obs_in [8];
    logic [CW-1:0] last_in;
    int obs_n, last_wr, last_hs, ff_cyc, rdy_cyc, err_cyc;
    int bad_onehot, bad_hold, bad_busy, extra_hs;
    int b_obs_n, b_last_wr, b_ff_cyc, b_rdy_cyc;
    bit poked_load, poked_arm;

    task automatic set_words(input bit rnd);
        for (int k = 0; k < NF; k++) begin
            word_tbl[k] = rnd ? CW'($urandom) : CW'((k + 1) * 17);
        end
`ifdef CFG_CHECKSUM_EN
        word_tbl[NF] = '0;
        for (int k = 0; k < NF; k++) word_tbl[NF] ^= word_tbl[k];
`endif
    endtask

    // Cycle at which ff_en should first be seen, relative to the end of the frame stream.
    function automatic int exp_ff(input int settle);
        int s_eff;
        s_eff = (settle > 0) ? settle : 1;
`ifdef CFG_CHECKSUM_EN
        return last_hs + 1 + s_eff;
`else
        return last_wr + 1 + s_eff;
`endif
    endfunction

    task automatic do_reset;
        @(negedge clock);
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
    endtask

    // Acts as the stream source; records what the loaders do until rdy or error.
    task automatic drive_load(input int stall_pct, input bit poke);
        int idx;
        idx = 0;
        obs_n = 0; last_wr = -1; last_hs = -1; ff_cyc = -1; rdy_cyc = -1; err_cyc = -1;
        bad_onehot = 0; bad_hold = 0; bad_busy = 0; extra_hs = 0;
        b_obs_n = 0; b_last_wr = -1; b_ff_cyc = -1; b_rdy_cyc = -1;
        poked_load = 1'b0; poked_arm = 1'b0; last_in = '0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (configs_en !== '0) begin
                if (obs_n < 8) begin
                    obs_en[obs_n] = configs_en;
                    obs_in[obs_n] = configs_in;
                end
                obs_n++;
                last_wr = cyc;
                last_in = configs_in;
                if (!$onehot(configs_en)) bad_onehot++;
            end else if (obs_n > 0 && configs_in !== last_in) begin
                bad_hold++;
            end
            if (b_configs_en !== '0) begin
                b_obs_n++;
                b_last_wr = cyc;
            end
            if (b_ff_en === 1'b1 && b_ff_cyc < 0) b_ff_cyc = cyc;
            if (b_rdy === 1'b1 && b_rdy_cyc < 0) b_rdy_cyc = cyc;
            if (ff_en === 1'b1 && ff_cyc < 0) ff_cyc = cyc;
            if (rdy === 1'b1) begin
                rdy_cyc = cyc;
                break;
            end
            if (error === 1'b1) begin
                err_cyc = cyc;
                break;
            end
            if (busy !== 1'b1) bad_busy++;
            if (idx < NW) begin
                cfg_valid = ($urandom_range(99) >= stall_pct);
                cfg_data  = cfg_valid ? word_tbl[idx] : CW'($urandom);
            end else begin
                cfg_valid = 1'($urandom_range(1));
                cfg_data  = CW'($urandom);
            end
            if (poke && !poked_load && cfg_ready === 1'b1 && obs_n == 1) begin
                start = 1'b1;
                poked_load = 1'b1;
            end
            if (poke && !poked_arm && ff_en === 1'b1) begin
                start = 1'b1;
                poked_arm = 1'b1;
            end
            if (cfg_valid && cfg_ready === 1'b1) begin
                if (idx < NW) begin
                    idx++;
                    last_hs = cyc;
                end else begin
                    extra_hs++;
                end
            end
        end
        start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [2*(CW+NF+FCW+5)-1:0] vec;
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hA5;
        @(negedge clock);
        vec = {configs_in, configs_en, ff_en, rdy, busy, error, cfg_ready, frame_count,
               b_configs_in, b_configs_en, b_ff_en, b_rdy, b_busy, b_error, b_cfg_ready, b_frame_count};
        checks++;
        if (vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", vec);
        end
        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic test_basic_load;
        do_reset();
        set_words(1'b0);
        @(negedge clock);
        start = 1'b1;
        drive_load(0, 1'b0);
        checks++;
        if (obs_n !== NF) begin
            errors++;
            $display("FAIL basic_write_count: got %0d expected %0d", obs_n, NF);
        end
        for (int k = 0; k < NF; k++) begin
            checks++;
            if (obs_en[k] !== NF'(1) << k || obs_in[k] !== word_tbl[k]) begin
                errors++;
                $display("FAIL basic_write%0d: got en=%b data=%h expected en=%b data=%h",
                         k, obs_en[k], obs_in[k], NF'(1) << k, word_tbl[k]);
            end
        end
        checks++;
        if (ff_cyc !== exp_ff(SC)) begin
            errors++;
            $display("FAIL basic_ff_en_time: got %0d expected %0d", ff_cyc, exp_ff(SC));
        end
        checks++;
        if (rdy_cyc !== ff_cyc + AC) begin
            errors++;
            $display("FAIL basic_rdy_time: got %0d expected %0d", rdy_cyc, ff_cyc + AC);
        end
        checks++;
        if (bad_onehot + bad_hold + bad_busy + extra_hs !== 0) begin
            errors++;
            $display("FAIL basic_stream_rules: got onehot=%0d hold=%0d busy=%0d extra=%0d expected all 0",
                     bad_onehot, bad_hold, bad_busy, extra_hs);
        end
        repeat (3) @(negedge clock);
        checks++;
        if ({ff_en, rdy, busy, cfg_ready, error} !== 5'b11000 || frame_count !== FCW'(NF)) begin
            errors++;
            $display("FAIL done_hold: got ff_en/rdy/busy/ready/error=%b frame_count=%0d expected 11000 count=%0d",
                     {ff_en, rdy, busy, cfg_ready, error}, frame_count, NF);
        end
    endtask

    task automatic test_random_gaps;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            set_words(1'b1);
            @(negedge clock);
            start = 1'b1;
            drive_load(50, 1'b0);
            checks++;
            if (obs_n !== NF || extra_hs !== 0 || bad_onehot !== 0) begin
                errors++;
                $display("FAIL gaps_count%0d: got writes=%0d extra=%0d onehot=%0d expected %0d 0 0",
                         it, obs_n, extra_hs, bad_onehot, NF);
            end
            for (int k = 0; k < NF; k++) begin
                checks++;
                if (obs_en[k] !== NF'(1) << k || obs_in[k] !== word_tbl[k]) begin
                    errors++;
                    $display("FAIL gaps_write%0d_%0d: got en=%b data=%h expected en=%b data=%h",
                             it, k, obs_en[k], obs_in[k], NF'(1) << k, word_tbl[k]);
                end
            end
            checks++;
            if (frame_count !== FCW'(NF) || ff_cyc !== exp_ff(SC) || bad_hold !== 0) begin
                errors++;
                $display("FAIL gaps_end%0d: got count=%0d ff_at=%0d hold=%0d expected %0d %0d 0",
                         it, frame_count, ff_cyc, bad_hold, NF, exp_ff(SC));
            end
        end
    endtask

    task automatic test_reset_mid_load;
        int idx;
        bit found;
        logic [CW+NF+FCW+4:0] vec;
        do_reset();
        set_words(1'b1);
        idx = 0;
        found = 1'b0;
        @(negedge clock);
        start = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (configs_en === NF'(4)) begin
                found = 1'b1;
                break;
            end
            cfg_valid = 1'b1;
            cfg_data = word_tbl[idx];
            if (cfg_ready === 1'b1 && idx < NF - 1) idx++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach_frame2: got no frame 2 write expected one within 40 cycles");
        end
        rst = 1'b1; start = 1'b1; cfg_valid = 1'b1;
        @(negedge clock);
        vec = {configs_in, configs_en, ff_en, rdy, busy, error, cfg_ready, frame_count};
        checks++;
        if (vec !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", vec);
        end
        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        @(negedge clock);
        start = 1'b1;
        drive_load(20, 1'b0);
        checks++;
        if (obs_n !== NF || obs_en[0] !== NF'(1) || obs_in[0] !== word_tbl[0] || rdy_cyc < 0) begin
            errors++;
            $display("FAIL midreset_reload: got writes=%0d first_en=%b first_data=%h rdy_at=%0d expected %0d 0001 %h >=0",
                     obs_n, obs_en[0], obs_in[0], rdy_cyc, NF, word_tbl[0]);
        end
    endtask

    task automatic test_start_ignored_and_restart;
        do_reset();
        set_words(1'b1);
        @(negedge clock);
        start = 1'b1;
        drive_load(30, 1'b1);
        checks++;
        if (obs_n !== NF || ff_cyc !== exp_ff(SC) || rdy_cyc !== ff_cyc + AC) begin
            errors++;
            $display("FAIL start_ignored: got writes=%0d ff_at=%0d rdy_at=%0d expected %0d %0d %0d",
                     obs_n, ff_cyc, rdy_cyc, NF, exp_ff(SC), exp_ff(SC) + AC);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if ({ff_en, rdy, busy, cfg_ready} !== 4'b0011 || frame_count !== '0) begin
            errors++;
            $display("FAIL done_restart: got ff_en/rdy/busy/ready=%b count=%0d expected 0011 count=0",
                     {ff_en, rdy, busy, cfg_ready}, frame_count);
        end
        set_words(1'b1);
        drive_load(10, 1'b0);
        checks++;
        if (obs_n !== NF || obs_en[0] !== NF'(1) || obs_in[0] !== word_tbl[0] || rdy_cyc < 0) begin
            errors++;
            $display("FAIL restart_reload: got writes=%0d first_en=%b first_data=%h rdy_at=%0d expected %0d 0001 %h >=0",
                     obs_n, obs_en[0], obs_in[0], rdy_cyc, NF, word_tbl[0]);
        end
    endtask

    task automatic test_zero_delay;
        do_reset();
        set_words(1'b1);
        @(negedge clock);
        start = 1'b1;
        drive_load(0, 1'b0);
        checks++;
        if (b_obs_n !== NF || b_last_wr !== last_wr) begin
            errors++;
            $display("FAIL zero_writes: got writes=%0d last_at=%0d expected %0d %0d", b_obs_n, b_last_wr, NF, last_wr);
        end
        checks++;
        if (b_ff_cyc !== exp_ff(0)) begin
            errors++;
            $display("FAIL zero_ff_en_time: got %0d expected %0d", b_ff_cyc, exp_ff(0));
        end
        checks++;
        if (b_rdy_cyc !== b_ff_cyc + 1) begin
            errors++;
            $display("FAIL zero_rdy_time: got %0d expected %0d", b_rdy_cyc, b_ff_cyc + 1);
        end
    endtask

`ifdef CFG_CHECKSUM_EN
    task automatic test_checksum_bad;
        int drops;
        do_reset();
        set_words(1'b0);
        word_tbl[NF] = 8'h45;
        @(negedge clock);
        start = 1'b1;
        drive_load(0, 1'b0);
        checks++;
        if (err_cyc !== last_hs + 1 || obs_n !== NF) begin
            errors++;
            $display("FAIL csum_error_time: got err_at=%0d writes=%0d expected %0d %0d", err_cyc, obs_n, last_hs + 1, NF);
        end
        checks++;
        if ({error, ff_en, rdy, busy, cfg_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL csum_error_outputs: got error/ff_en/rdy/busy/ready=%b expected 10000",
                     {error, ff_en, rdy, busy, cfg_ready});
        end
        drops = 0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'($urandom_range(1));
            cfg_data = CW'($urandom);
            @(negedge clock);
            if (error !== 1'b1 || busy !== 1'b0 || ff_en !== 1'b0 || rdy !== 1'b0) drops++;
        end
        cfg_valid = 1'b0;
        checks++;
        if (drops !== 0) begin
            errors++;
            $display("FAIL csum_error_hold: got %0d bad cycles expected 0", drops);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if ({error, busy, cfg_ready} !== 3'b011) begin
            errors++;
            $display("FAIL csum_error_restart: got error/busy/ready=%b expected 011", {error, busy, cfg_ready});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_random_gaps();
        test_reset_mid_load();
        test_start_ignored_and_restart();
        test_zero_delay();
`ifdef CFG_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
